// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write controllers.
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 3;
   localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

   // Controller states. The write-side controller adds WRITE/WR_ERROR.
   typedef enum logic [1:0] {
      INIT     = 2'b00,
      NO_OP    = 2'b01,
      READ     = 2'b10,
      RD_ERROR = 2'b11
   } state_t;

endpackage

// File: rtl/read_operation.sv
// Combinational entry select for the register file: a decoder turns the
// read index into a one-hot select, then an AND-OR tree picks the entry.
module read_operation
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0]                 i_addr,
   input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] i_rfData,
   output logic [DATA_WIDTH-1:0]                 o_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0] w_sel;

   // Decode the read index into a one-hot entry select.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_sel[i] = (i_addr == ADDR_WIDTH'(i));
      end
   end

   // Gate each entry with its select line and OR the results together.
   always_comb begin
      o_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_data = o_data | (i_rfData[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[i]}});
      end
   end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: owns the read pointer, serves registered read
// data with an ack/error handshake and reports empty/occupancy.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 rd_en,
   input  logic [ADDR_WIDTH:0]                  wr_ptr,
   input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] rf_data,
   output logic [ADDR_WIDTH:0]                  rd_ptr,
   output logic [DATA_WIDTH-1:0]                dout,
   output logic                                 rd_ack,
   output logic                                 rd_err,
   output logic                                 empty,
   output logic [ADDR_WIDTH:0]                  data_count
);

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_WIDTH:0]   r_rdPtr;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] w_entry;
   logic                  w_empty;
   logic                  w_readOk;

   // Pointers carry a wrap bit, so equal pointers mean empty and the
   // modular difference gives occupancy 0..DEPTH.
   assign w_empty    = (r_rdPtr == wr_ptr);
   assign w_readOk   = rd_en && !w_empty;
   assign empty      = w_empty;
   assign data_count = wr_ptr - r_rdPtr;
   assign rd_ptr     = r_rdPtr;
   assign dout       = r_dout;

   read_operation #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_readOperation (
      .i_addr   (r_rdPtr[ADDR_WIDTH-1:0]),
      .i_rfData (rf_data),
      .o_data   (w_entry)
   );

   // Next state depends only on the request and the current empty flag.
   always_comb begin
      w_nextState = NO_OP;
      if (rd_en) begin
         w_nextState = w_empty ? RD_ERROR : READ;
      end
   end

   // Handshake pulses are decoded from the registered state only.
   always_comb begin
      rd_ack = 1'b0;
      rd_err = 1'b0;
      case (r_state)
         READ:     rd_ack = 1'b1;
         RD_ERROR: rd_err = 1'b1;
         default: begin
            rd_ack = 1'b0;
            rd_err = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Successful reads capture the selected entry and advance the pointer;
   // dout otherwise holds until the next read or reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rdPtr <= '0;
         r_dout  <= '0;
      end else if (w_readOk) begin
         r_dout  <= w_entry;
         r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// pointer/occupancy model of the FIFO read side.
module tb_fifo_read_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  rd_en = 1'b0;
   logic [AW:0]           wr_ptr = '0;
   logic [DEPTH*DW-1:0]   rf_data = '0;
   logic [AW:0]           rd_ptr;
   logic [DW-1:0]         dout;
   logic                  rd_ack;
   logic                  rd_err;
   logic                  empty;
   logic [AW:0]           data_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: read pointer as an integer 0..15.
   int          mPtr = 0;
   logic [31:0] mDout = '0;
   logic        mAck = 1'b0;
   logic        mErr = 1'b0;

   fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (rd_en),
      .wr_ptr     (wr_ptr),
      .rf_data    (rf_data),
      .rd_ptr     (rd_ptr),
      .dout       (dout),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err),
      .empty      (empty),
      .data_count (data_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rn, input logic re, input logic [AW:0] wp);
      @(negedge clk);
      reset_n = rn;
      rd_en   = re;
      wr_ptr  = wp;
      @(posedge clk);
      #2;
   endtask

   task automatic setEntry(input int idx, input logic [31:0] val);
      rf_data[idx*DW +: DW] = val;
   endtask

   // Model update on each edge from the sampled inputs, then compare every output.
   always @(posedge clk) begin
      int occ;
      occ = (int'(wr_ptr) - mPtr + 16) % 16;
      if (!reset_n) begin
         mPtr  = 0;
         mDout = '0;
         mAck  = 1'b0;
         mErr  = 1'b0;
      end else if (rd_en && occ != 0) begin
         mDout = rf_data[(mPtr % DEPTH)*DW +: DW];
         mPtr  = (mPtr + 1) % 16;
         mAck  = 1'b1;
         mErr  = 1'b0;
      end else begin
         mAck  = 1'b0;
         mErr  = rd_en;
      end
      #1;
      occ = (int'(wr_ptr) - mPtr + 16) % 16;
      checkOutput("rd_ptr", 64'(rd_ptr), 64'(mPtr));
      checkOutput("dout", 64'(dout), 64'(mDout));
      checkOutput("rd_ack", 64'(rd_ack), 64'(mAck));
      checkOutput("rd_err", 64'(rd_err), 64'(mErr));
      checkOutput("data_count", 64'(data_count), 64'(occ));
      checkOutput("empty", 64'(empty), 64'(occ == 0));
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [AW:0] wp;
      int          occ;

      // Reset held with a pending read request.
      applyStimulus(1'b0, 1'b1, 4'd0);
      applyStimulus(1'b0, 1'b1, 4'd0);
      checkOutput("rst_rd_ptr", 64'(rd_ptr), 64'd0);
      checkOutput("rst_dout", 64'(dout), 64'd0);
      checkOutput("rst_ack", 64'(rd_ack), 64'd0);
      checkOutput("rst_err", 64'(rd_err), 64'd0);
      checkOutput("rst_empty", 64'(empty), 64'd1);
      checkOutput("rst_count", 64'(data_count), 64'd0);

      // Empty read.
      applyStimulus(1'b1, 1'b1, 4'd0);
      checkOutput("emp_err", 64'(rd_err), 64'd1);
      checkOutput("emp_ptr", 64'(rd_ptr), 64'd0);
      checkOutput("emp_dout", 64'(dout), 64'd0);
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("emp_err_drop", 64'(rd_err), 64'd0);

      // Three single reads then an empty read.
      setEntry(0, 32'hA0); setEntry(1, 32'hA1); setEntry(2, 32'hA2);
      applyStimulus(1'b1, 1'b1, 4'd3);
      checkOutput("rd0", 64'(dout), 64'hA0);
      checkOutput("ack0", 64'(rd_ack), 64'd1);
      applyStimulus(1'b1, 1'b1, 4'd3);
      checkOutput("rd1", 64'(dout), 64'hA1);
      checkOutput("ack1", 64'(rd_ack), 64'd1);
      applyStimulus(1'b1, 1'b1, 4'd3);
      checkOutput("rd2", 64'(dout), 64'hA2);
      checkOutput("ack2", 64'(rd_ack), 64'd1);
      checkOutput("rd3_ptr", 64'(rd_ptr), 64'd3);
      checkOutput("rd3_empty", 64'(empty), 64'd1);
      checkOutput("rd3_count", 64'(data_count), 64'd0);
      applyStimulus(1'b1, 1'b1, 4'd3);
      checkOutput("rd4_err", 64'(rd_err), 64'd1);
      checkOutput("rd4_dout_hold", 64'(dout), 64'hA2);

      // Move read pointer to 6, then wrap through 7 and 0.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'd6);
      checkOutput("pre_wrap_ptr", 64'(rd_ptr), 64'd6);
      setEntry(6, 32'hC6); setEntry(7, 32'hC7); setEntry(0, 32'hC0);
      applyStimulus(1'b1, 1'b0, 4'b1001);
      checkOutput("wrap_count", 64'(data_count), 64'd3);
      applyStimulus(1'b1, 1'b1, 4'b1001);
      checkOutput("wrap_e6", 64'(dout), 64'hC6);
      applyStimulus(1'b1, 1'b1, 4'b1001);
      checkOutput("wrap_e7", 64'(dout), 64'hC7);
      applyStimulus(1'b1, 1'b1, 4'b1001);
      checkOutput("wrap_e0", 64'(dout), 64'hC0);
      checkOutput("wrap_ptr", 64'(rd_ptr), 64'b1001);
      checkOutput("wrap_empty", 64'(empty), 64'd1);

      // Full FIFO drained by eight back-to-back reads.
      applyStimulus(1'b0, 1'b0, 4'd0);
      for (int i = 0; i < DEPTH; i++) setEntry(i, 32'h100 + i);
      applyStimulus(1'b1, 1'b0, 4'b1000);
      checkOutput("full_count", 64'(data_count), 64'd8);
      checkOutput("full_empty", 64'(empty), 64'd0);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b1, 4'b1000);
         checkOutput($sformatf("full_rd%0d", i), 64'(dout), 64'(32'h100 + i));
         checkOutput($sformatf("full_ack%0d", i), 64'(rd_ack), 64'd1);
      end
      checkOutput("full_ptr", 64'(rd_ptr), 64'b1000);

      // First write coincides with a read on an empty FIFO.
      applyStimulus(1'b0, 1'b0, 4'd0);
      setEntry(0, 32'hBEEF);
      applyStimulus(1'b1, 1'b1, 4'd0);
      checkOutput("wr_rd_err", 64'(rd_err), 64'd1);
      applyStimulus(1'b1, 1'b1, 4'd1);
      checkOutput("wr_rd_ack", 64'(rd_ack), 64'd1);
      checkOutput("wr_rd_dout", 64'(dout), 64'hBEEF);

      // Reset in the middle of a burst.
      applyStimulus(1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) setEntry(i, 32'hD0 + i);
      applyStimulus(1'b1, 1'b1, 4'd4);
      applyStimulus(1'b1, 1'b1, 4'd4);
      checkOutput("burst_dout", 64'(dout), 64'hD1);
      applyStimulus(1'b0, 1'b1, 4'd0);
      checkOutput("mid_rst_ptr", 64'(rd_ptr), 64'd0);
      checkOutput("mid_rst_dout", 64'(dout), 64'd0);
      checkOutput("mid_rst_ack", 64'(rd_ack), 64'd0);
      checkOutput("mid_rst_err", 64'(rd_err), 64'd0);

      // Randomized traffic: writes only while the FIFO has room.
      wp = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 63) == 0) begin
            reset_n = 1'b0;
            wp      = '0;
         end else begin
            reset_n = 1'b1;
            occ = (int'(wp) - mPtr + 16) % 16;
            if ($urandom_range(0, 1) == 1 && occ < DEPTH) begin
               setEntry(int'(wp[AW-1:0]), $urandom);
               wp = wp + 1'b1;
            end
         end
         rd_en  = ($urandom_range(0, 2) != 0);
         wr_ptr = wp;
      end
      @(negedge clk);
      rd_en = 1'b0;
      @(posedge clk);
      #3;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the 8-entry FIFO register file. It is the counterpart of the write-enable decoder path on the write side. The block owns the read pointer and computes empty and occupancy from the write-side pointer. It serves registered read data to the consumer with an ack/error handshake. Its rd_ptr output is returned to the write side for full detection.

Parameters:
DATA_WIDTH, 32, width of one FIFO entry
ADDR_WIDTH, 3, entry index width; DEPTH = 2**ADDR_WIDTH = 8

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
rd_en  input  1  consumer read request, sampled each rising edge
wr_ptr  input  ADDR_WIDTH+1  write-side pointer, registered upstream; MSB is wrap bit
rf_data  input  DEPTH*DATA_WIDTH  flattened register-file contents, entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
rd_ptr  output  ADDR_WIDTH+1  read pointer; MSB is wrap bit
dout  output  DATA_WIDTH  registered read data
rd_ack  output  1  one-cycle pulse: dout updated by a successful read
rd_err  output  1  one-cycle pulse: read attempted while empty
empty  output  1  rd_ptr == wr_ptr
data_count  output  ADDR_WIDTH+1  wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1), range 0..DEPTH

Behaviour:
- Reset is synchronous and active-low: on a clk edge with reset_n=0, the block sets rd_ptr=0, dout=0, rd_ack=0, rd_err=0 and state=INIT. Reset takes priority over rd_en.
- The state register has four states: INIT, NO_OP, READ, RD_ERROR. The encoding is 2-bit binary, with INIT=2'b00.
- Next state, evaluated every edge out of reset, regardless of current state:
  - rd_en=0 -> NO_OP
  - rd_en=1 and empty=0 -> READ
  - rd_en=1 and empty=1 -> RD_ERROR
- Outputs are decoded from the registered state and updated registers, so there is no combinational path from rd_en to any output:
  - READ: rd_ack=1, rd_err=0
  - RD_ERROR: rd_err=1, rd_ack=0
  - INIT and NO_OP: both 0
- Read action, on an edge where rd_en=1 and empty=0:
  - dout <= rf_data entry at index rd_ptr[ADDR_WIDTH-1:0]
  - rd_ptr <= rd_ptr+1
- Latency: a request sampled at edge N produces valid dout and rd_ack=1 during cycle N..N+1.
- Back-to-back reads: rd_en held high returns one entry per cycle, and rd_ack stays high for consecutive cycles.
- dout holds its value in NO_OP and RD_ERROR. It never returns to 0 except on reset.
- Empty read: rd_ptr is unchanged, dout is unchanged, and rd_err pulses.
- Wrap-around: the pointer is ADDR_WIDTH+1 bits. Going from index 7 to 0 toggles the MSB, and the increment from 4'b1111 gives 4'b0000. empty and data_count stay correct across wrap.
- empty and data_count are combinational from rd_ptr and wr_ptr. With wr_ptr MSB differing and the low bits equal, data_count=8.
- Simultaneous write and read on an empty FIFO: the wr_ptr value sampled at the edge governs, and there is no bypass. A read in the same cycle as the first write returns rd_err; the entry is readable on the following edge.
- wr_ptr consistency (data_count <= DEPTH) is guaranteed by the write side and is not checked here.
- Reset during a read burst: the next edge with reset_n=0 clears all state. Any entries not yet read are logically discarded; the write side is reset together with this block.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - DEPTH
  - the state type and encodings INIT/NO_OP/READ/RD_ERROR (shared with the write-side controller, which adds WRITE/WR_ERROR)
- One sub-module, read_operation: the combinational DEPTH-to-1 entry select driven by rd_ptr[ADDR_WIDTH-1:0], built as a 3-to-8 decoder plus AND-OR. It is the read-side mirror of the write-enable decoder.
- The controller holds the pointer, the state register, dout and the flag logic.

Test Plan:
1. Reset with reset_n=0 for 2 edges and rd_en=1 -> rd_ptr=0, dout=0, rd_ack=0, rd_err=0, empty=1, data_count=0.
2. Empty read with wr_ptr=0 and rd_en=1 for 1 edge -> rd_err=1 for one cycle; rd_ptr stays 0 and dout stays 0.
3. Single read with entries 0..2 = 32'hA0, 32'hA1, 32'hA2 and wr_ptr=3, then rd_en high for 3 edges -> dout = A0, A1, A2 on successive cycles, rd_ack high for 3 cycles, then rd_ptr=3, empty=1, data_count=0. A fourth edge with rd_en high gives rd_err=1.
4. Wrap-around with rd_ptr=4'b0110 and wr_ptr=4'b1001 (data_count=3), then 3 reads -> entries 6, 7, 0 are read in order; rd_ptr=4'b1001 and empty=1.
5. Full FIFO with wr_ptr=4'b1000 and rd_ptr=0 -> data_count=8 and empty=0. After 8 reads, entries 0..7 have been read and rd_ptr=4'b1000.
6. Write and read together on an empty FIFO: wr_ptr goes 0->1 on the same edge that rd_en=1 is sampled -> rd_err=1. The next edge with rd_en=1 gives rd_ack=1 with dout = entry 0.
7. Reset mid-burst: after 2 of 4 reads, reset_n=0 for 1 edge -> rd_ptr=0, dout=0, no ack or err in the cycle after reset.
